pipe_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Collects stall requests from IF, ID, EX and MEM, plus branch redirects from EX and fence requests from ID.
- Drives per-register hold (stall) and bubble-insert (flush) controls for pc, if_id, id_ex, ex_mem and mem_wb.
- Owns a small FSM that drains the pipeline for FENCE, so mem_wb and the other pipeline registers stay purely passive.

---
 rtl/pipe_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline, including FENCE drain FSM.
// Optional stall watchdog enabled by defining PIPE_STALL_WDT_EN.
module pipe_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int WDT_LIMIT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              fence_req,
    output logic [4:0]        stall,
    output logic [4:0]        flush,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              fence_done,
    output logic              stall_timeout
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   drain_cnt;
    logic               fence_block;
    logic               busy;
    logic               branch_ok;

    assign busy      = stallreq_ex | stallreq_mem;
    assign branch_ok = branch_flag & ~busy & ~rst;

    always_comb begin
        stall       = 5'b00000;
        flush       = 5'b00000;
        pc_redirect = 1'b0;
        redirect_pc = '0;
        if (rst) begin
            flush = 5'b11111;
        end else if (branch_ok) begin
            flush       = 5'b00110;
            pc_redirect = 1'b1;
            redirect_pc = branch_target;
        end else if (stallreq_mem) begin
            stall = 5'b01111;
        end else if (stallreq_ex) begin
            stall = 5'b00111;
        end else if (stallreq_id || state == DRAIN) begin
            stall = 5'b00011;
        end else if (stallreq_if) begin
            stall = 5'b00001;
        end
    end

    // fence_block masks the fence that just completed while it leaves ID
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            drain_cnt   <= '0;
            fence_done  <= 1'b0;
            fence_block <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    fence_done  <= 1'b0;
                    fence_block <= 1'b0;
                    if (fence_req && !fence_block && !branch_ok && !busy) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (branch_ok) begin
                        state <= RUN;
                    end else if (!busy) begin
                        if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                            state      <= DONE;
                            fence_done <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state       <= RUN;
                    fence_done  <= 1'b0;
                    fence_block <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_WDT_EN
    localparam int WDT_W = ($clog2(WDT_LIMIT + 1) > 10) ?
                           $clog2(WDT_LIMIT + 1) : 10;

    logic [WDT_W-1:0] wdt_cnt;
    logic             wdt_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt  <= '0;
            wdt_flag <= 1'b0;
        end else if (stall[0]) begin
            if (wdt_cnt != WDT_W'(WDT_LIMIT))
                wdt_cnt <= wdt_cnt + 1'b1;
            if (wdt_cnt == WDT_W'(WDT_LIMIT - 1))
                wdt_flag <= 1'b1;
        end else begin
            wdt_cnt <= '0;
        end
    end

    assign stall_timeout = wdt_flag;
`else
    localparam int wdt_limit_unused = WDT_LIMIT;
    assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: random and directed stimulus against a
// cycle-level reference model of the stall/flush/fence rules.
module tb_pipe_ctrl;

    localparam int AW = 32;
    localparam int DC = 3;
    localparam int WL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic          branch_flag;
    logic [AW-1:0] branch_target;
    logic          fence_req;
    logic [4:0]    stall, flush;
    logic          pc_redirect;
    logic [AW-1:0] redirect_pc;
    logic          fence_done;
    logic          stall_timeout;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .ADDR_W(AW),
        .DRAIN_CYCLES(DC),
        .WDT_LIMIT(WL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stallreq_if(stallreq_if),
        .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .branch_flag(branch_flag),
        .branch_target(branch_target),
        .fence_req(fence_req),
        .stall(stall),
        .flush(flush),
        .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc),
        .fence_done(fence_done),
        .stall_timeout(stall_timeout)
    );

    typedef struct packed {
        logic [4:0]    st;
        logic [4:0]    fl;
        logic          pr;
        logic [AW-1:0] pc;
        logic          fd;
        logic          to;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state
    bit m_drain = 0;
    bit m_done  = 0;
    bit m_cool  = 0;
    bit m_to    = 0;
    int m_left  = 0;
    int m_wdt   = 0;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", n, $time, act, want);
        end
    endtask

    task automatic step(input bit r, input bit s_if, input bit s_id,
                        input bit s_ex, input bit s_mem, input bit b,
                        input logic [AW-1:0] tgt, input bit f);
        exp_t e;
        bit   br;
        int   depth;
        rst           = r;
        stallreq_if   = s_if;
        stallreq_id   = s_id;
        stallreq_ex   = s_ex;
        stallreq_mem  = s_mem;
        branch_flag   = b;
        branch_target = tgt;
        fence_req     = f;
        br = b && !s_ex && !s_mem && !r;
        e  = '0;
        if (r) begin
            e.fl = 5'b11111;
        end else if (br) begin
            e.fl = 5'b00110;
            e.pr = 1'b1;
            e.pc = tgt;
        end else begin
            // number of leading registers held, counted from pc upward
            depth = s_mem ? 4 : s_ex ? 3 : (s_id || m_drain) ? 2 : s_if ? 1 : 0;
            e.st = 5'((1 << depth) - 1);
        end
        e.fd = m_done;
        e.to = m_to;
        sb.push_back(e);
        if (r) begin
            m_drain = 0; m_done = 0; m_cool = 0; m_wdt = 0; m_to = 0;
        end else begin
            if (m_done) begin
                m_done = 0;
                m_cool = 1;
            end else if (m_drain) begin
                if (br) begin
                    m_drain = 0;
                end else if (!s_ex && !s_mem) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_drain = 0;
                        m_done  = 1;
                    end
                end
            end else begin
                if (f && !m_cool && !br && !s_ex && !s_mem) begin
                    m_drain = 1;
                    m_left  = DC;
                end
                m_cool = 0;
            end
`ifdef PIPE_STALL_WDT_EN
            if (e.st[0]) begin
                m_wdt++;
                if (m_wdt >= WL) m_to = 1;
            end else begin
                m_wdt = 0;
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit f);
        step(0, 0, 0, 0, 0, 0, '0, f);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall", 64'(stall), 64'(e.st));
                chk("flush", 64'(flush), 64'(e.fl));
                chk("pc_redirect", 64'(pc_redirect), 64'(e.pr));
                chk("redirect_pc", 64'(redirect_pc), 64'(e.pc));
                chk("fence_done", 64'(fence_done), 64'(e.fd));
                chk("stall_timeout", 64'(stall_timeout), 64'(e.to));
            end
        end
    end

    initial begin : stim
        rst = 1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0;
        stallreq_mem = 0; branch_flag = 0; branch_target = '0; fence_req = 0;
        @(posedge clk);
        #1;
        // reset, then quiet
        step(1, 0, 0, 0, 0, 0, '0, 0);
        step(1, 0, 0, 0, 0, 1, 32'h55, 1);
        idle(0);
        idle(0);
        // mem + id together, then id alone
        repeat (3) step(0, 0, 1, 0, 1, 0, '0, 0);
        step(0, 0, 1, 0, 0, 0, '0, 0);
        // branch beats id stall; ex stall blocks branch
        step(0, 0, 1, 0, 0, 1, 32'h0000_1040, 0);
        step(0, 0, 0, 1, 0, 1, 32'h0000_1040, 0);
        idle(0);
        // fence drain with a 2-cycle mem stall mid-drain
        idle(1);
        idle(1);
        step(0, 0, 0, 0, 1, 0, '0, 1);
        step(0, 0, 0, 0, 1, 0, '0, 1);
        idle(1);
        idle(1);
        idle(1);
        idle(0);
        idle(0);
        // branch in second drain cycle kills the fence
        idle(1);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 32'h0000_2000, 1);
        repeat (5) idle(0);
        // long fetch stall, then reset
        repeat (10) step(0, 1, 0, 0, 0, 0, '0, 0);
        idle(0);
        step(1, 0, 0, 0, 0, 0, '0, 0);
        idle(0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 1,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 12,
                 AW'($urandom),
                 $urandom_range(0, 99) < 30);
        end
        repeat (2) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
